// File: rtl/ray_dispatcher.sv
// ray_dispatcher: frame scheduler in front of the voxel traversal unit (VTU).
// Latches a camera, walks the screen in raster order launching one primary
// ray at a time, shades each hit by block type and face normal, and writes
// one RGB565 pixel per ray to the framebuffer port with backpressure.
//
// Vectors are packed as {x, y, z}, each component a B-bit two's complement
// fixed-point value: x = [3B-1:2B], y = [2B-1:B], z = [B-1:0].
// The block-colour palette is supplied as a packed parameter, entry k at
// bits [16k+15:16k], indexed by the BlockType value (BLOCK_AIR = 0).
module ray_dispatcher #(
    parameter int                          H_RES     = 320,
    parameter int                          V_RES     = 180,
    parameter int                          PIX_SHIFT = 7,
    parameter logic [15:0]                 SKY_COLOR = 16'h867D,
    parameter int                          B         = 16,
    parameter int                          BT_W      = 4,
    parameter logic [16*(2**BT_W)-1:0]     PALETTE   = {
        16'h5AEB, 16'h9A52, 16'hC3A0, 16'h2945, 16'h07FF, 16'hF81F, 16'hFFE0, 16'h8410,
        16'h4208, 16'h1234, 16'hABCD, 16'h001F, 16'h07E0, 16'hF800, 16'hFFFF, 16'h0000}
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              frame_start,
    input  logic [3*B-1:0]                    cam_pos,
    input  logic [3*B-1:0]                    cam_forward,
    input  logic [3*B-1:0]                    cam_right,
    input  logic [3*B-1:0]                    cam_up,
    output logic                              frame_busy,
    output logic                              frame_done,
    output logic                              vtu_rst,
    output logic [3*B-1:0]                    vtu_ray_origin,
    output logic [3*B-1:0]                    vtu_ray_direction,
    input  logic [BT_W-1:0]                   vtu_hit,
    input  logic [3*B-1:0]                    vtu_hit_norm,
    input  logic                              vtu_hit_valid,
    output logic [$clog2(H_RES*V_RES)-1:0]    px_addr,
    output logic [15:0]                       px_data,
    output logic                              px_valid,
    input  logic                              px_ready
);

    localparam int                AW         = $clog2(H_RES*V_RES);
    localparam int                XW         = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam logic [AW-1:0]     LAST_PIX   = AW'(H_RES*V_RES-1);
    localparam logic [XW-1:0]     LAST_X     = XW'(H_RES-1);
    localparam logic [B-1:0]      HALF_H     = B'(H_RES/2);
    localparam logic [B-1:0]      HALF_V     = B'(V_RES/2);
    localparam logic [BT_W-1:0]   BLOCK_AIR  = '0;

    typedef enum logic [2:0] {
        IDLE, SETUP0, SETUP1, LAUNCH, WAIT, SHADE, WRITE, ADVANCE
    } state_t;

    // Componentwise fixed-point helpers; all results wrap at B bits.
    function automatic logic [3*B-1:0] vec_add(input logic [3*B-1:0] a, input logic [3*B-1:0] b);
        logic [3*B-1:0] r;
        for (int i = 0; i < 3; i++) r[i*B +: B] = a[i*B +: B] + b[i*B +: B];
        return r;
    endfunction

    function automatic logic [3*B-1:0] vec_sub(input logic [3*B-1:0] a, input logic [3*B-1:0] b);
        logic [3*B-1:0] r;
        for (int i = 0; i < 3; i++) r[i*B +: B] = a[i*B +: B] - b[i*B +: B];
        return r;
    endfunction

    function automatic logic [3*B-1:0] vec_sra(input logic [3*B-1:0] a);
        logic [3*B-1:0]      r;
        logic signed [B-1:0] c;
        for (int i = 0; i < 3; i++) begin
            c = a[i*B +: B];
            r[i*B +: B] = c >>> PIX_SHIFT;
        end
        return r;
    endfunction

    function automatic logic [3*B-1:0] vec_scale(input logic [3*B-1:0] a, input logic [B-1:0] k);
        logic [3*B-1:0] r;
        for (int i = 0; i < 3; i++) r[i*B +: B] = a[i*B +: B] * k;
        return r;
    endfunction

    state_t            r_state;
    logic [3*B-1:0]    r_cam_pos, r_cam_fwd, r_cam_right, r_cam_up;
    logic [3*B-1:0]    r_du, r_dv, r_row_dir, r_dir;
    logic [XW-1:0]     r_x;
    logic [AW-1:0]     r_pix;
    logic [BT_W-1:0]   r_hit;
    logic [3*B-1:0]    r_norm;
    logic              r_frame_busy, r_frame_done, r_vtu_rst, r_px_valid;
    logic [AW-1:0]     r_px_addr;
    logic [15:0]       r_px_data;

    logic [3*B-1:0]    w_row_dir0;
    logic [15:0]       w_base, w_shaded;
    logic [4:0]        w_r, w_b, w_sr, w_sb;
    logic [5:0]        w_g, w_sg;
    logic [B-1:0]      w_nx, w_ny, w_nz;

    // Top-left ray: forward, stepped left by half a row and up by half a column.
    assign w_row_dir0 = vec_sub(vec_add(r_cam_fwd, vec_scale(r_dv, HALF_V)), vec_scale(r_du, HALF_H));

    assign w_nx = r_norm[3*B-1:2*B];
    assign w_ny = r_norm[2*B-1:B];
    assign w_nz = r_norm[B-1:0];

    // Shade the captured hit: palette colour dimmed per channel by face orientation.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_base = PALETTE[{r_hit, 4'b0000} +: 16];
        w_r    = w_base[15:11];
        w_g    = w_base[10:5];
        w_b    = w_base[4:0];
        w_sr   = w_r;
        w_sg   = w_g;
        w_sb   = w_b;
        if (w_nx != '0) begin
            w_sr = w_r - (w_r >> 2);
            w_sg = w_g - (w_g >> 2);
            w_sb = w_b - (w_b >> 2);
        end else if (w_nz != '0) begin
            w_sr = w_r >> 1;
            w_sg = w_g >> 1;
            w_sb = w_b >> 1;
        end else if (w_ny != '0 && w_ny[B-1]) begin
            w_sr = w_r >> 2;
            w_sg = w_g >> 2;
            w_sb = w_b >> 2;
        end
        w_shaded = (r_hit == BLOCK_AIR) ? SKY_COLOR : {w_sr, w_sg, w_sb};
    end

    // Frame/pixel sequencer with all outputs registered.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_in) begin
            r_state      <= IDLE;
            r_cam_pos    <= '0;
            r_cam_fwd    <= '0;
            r_cam_right  <= '0;
            r_cam_up     <= '0;
            r_du         <= '0;
            r_dv         <= '0;
            r_row_dir    <= '0;
            r_dir        <= '0;
            r_x          <= '0;
            r_pix        <= '0;
            r_hit        <= '0;
            r_norm       <= '0;
            r_frame_busy <= 1'b0;
            r_frame_done <= 1'b0;
            r_vtu_rst    <= 1'b0;
            r_px_valid   <= 1'b0;
            r_px_addr    <= '0;
            r_px_data    <= '0;
        end else begin
            r_frame_done <= 1'b0;
            r_vtu_rst    <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A request coinciding with the done pulse is dropped.
                    if (frame_start && !r_frame_done) begin
                        r_cam_pos    <= cam_pos;
                        r_cam_fwd    <= cam_forward;
                        r_cam_right  <= cam_right;
                        r_cam_up     <= cam_up;
                        r_x          <= '0;
                        r_pix        <= '0;
                        r_frame_busy <= 1'b1;
                        r_state      <= SETUP0;
                    end
                end
                SETUP0: begin
                    r_du    <= vec_sra(r_cam_right);
                    r_dv    <= vec_sra(r_cam_up);
                    r_state <= SETUP1;
                end
                SETUP1: begin
                    r_row_dir <= w_row_dir0;
                    r_dir     <= w_row_dir0;
                    r_vtu_rst <= 1'b1;
                    r_state   <= LAUNCH;
                end
                LAUNCH: begin
                    // A hit still held from the previous ray is not looked at here.
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (vtu_hit_valid) begin
                        r_hit   <= vtu_hit;
                        r_norm  <= vtu_hit_norm;
                        r_state <= SHADE;
                    end
                end
                SHADE: begin
                    r_px_data  <= w_shaded;
                    r_px_addr  <= r_pix;
                    r_px_valid <= 1'b1;
                    r_state    <= WRITE;
                end
                WRITE: begin
                    if (px_ready) begin
                        r_px_valid <= 1'b0;
                        r_state    <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (r_pix == LAST_PIX) begin
                        r_frame_done <= 1'b1;
                        r_frame_busy <= 1'b0;
                        r_state      <= IDLE;
                    end else begin
                        if (r_x < LAST_X) begin
                            r_x   <= r_x + 1'b1;
                            r_dir <= vec_add(r_dir, r_du);
                        end else begin
                            // Both take the old row start, so the new row begins one dv lower.
                            r_x       <= '0;
                            r_row_dir <= vec_sub(r_row_dir, r_dv);
                            r_dir     <= vec_sub(r_row_dir, r_dv);
                        end
                        r_pix     <= r_pix + 1'b1;
                        r_vtu_rst <= 1'b1;
                        r_state   <= LAUNCH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign frame_busy        = r_frame_busy;
    assign frame_done        = r_frame_done;
    assign vtu_rst           = r_vtu_rst;
    assign vtu_ray_origin    = r_cam_pos;
    assign vtu_ray_direction = r_dir;
    assign px_addr           = r_px_addr;
    assign px_data           = r_px_data;
    assign px_valid          = r_px_valid;

endmodule
